// File: rtl/alu_op_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_seq_pkg
//  Description : Shared widths, opcodes, FSM states and overflow helper for
//                the ALU command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_op_seq_pkg;

    localparam int DW   = 5;
    localparam int NREG = 4;
    localparam int AW   = 2;

    // Opcodes share the ALU Sel encoding so alu_sel can be driven straight from them
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    function automatic logic calc_ovf(
        input logic [1:0]    sel,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] r
    );
        logic ovf;
        ovf = 1'b0;
        case (sel)
            OP_ADD:  ovf = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            OP_SUB:  ovf = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_seq_if
//  Description : Command handshake and result strobe bundle of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_seq_if;
    import alu_op_seq_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_src1;
    logic [AW-1:0] cmd_src2;
    logic [DW-1:0] cmd_imm;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_dst;
    logic          res_ovf;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
        input  cmd_ready, res_valid, res_data, res_dst, res_ovf
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
        output cmd_ready, res_valid, res_data, res_dst, res_ovf
    );

endinterface
`default_nettype wire

// File: rtl/alu_op_seq_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_seq_regfile
//  Description : NREG x DW register file, one sync write, three comb reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_seq_regfile
    import alu_op_seq_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic [AW-1:0] i_raddr1,
    input  wire logic [AW-1:0] i_raddr2,
    input  wire logic [AW-1:0] i_raddr3,
    output logic      [DW-1:0] o_rdata1,
    output logic      [DW-1:0] o_rdata2,
    output logic      [DW-1:0] o_rdata3
);

    logic [NREG-1:0][DW-1:0] r_regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];
    assign o_rdata3 = r_regs[i_raddr3];

endmodule
`default_nettype wire

// File: rtl/alu_op_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_seq
//  Description : IDLE/EXEC/WB command sequencer feeding an external 5-bit ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_seq
    import alu_op_seq_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_op_seq_if.slave        cmd_if,
    output logic      [DW-1:0] alu_din1,
    output logic      [DW-1:0] alu_din2,
    output logic      [1:0]    alu_sel,
    input  wire logic [DW-1:0] alu_out,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [DW-1:0] rd_data
);

    state_t        r_state;
    state_t        w_next_state;
    logic          w_ready;
    logic          w_wb;
    logic          w_accept;
    logic          w_ovf;
    logic [DW-1:0] w_src1_data;
    logic [DW-1:0] w_src2_data;
    logic [DW-1:0] r_din1;
    logic [DW-1:0] r_din2;
    logic [1:0]    r_sel;
    logic [AW-1:0] r_dst;
    logic [DW-1:0] r_res_data;
    logic [AW-1:0] r_res_dst;
    logic          r_res_ovf;

    alu_op_seq_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_wb),
        .i_waddr  (r_res_dst),
        .i_wdata  (r_res_data),
        .i_raddr1 (cmd_if.cmd_src1),
        .i_raddr2 (cmd_if.cmd_src2),
        .i_raddr3 (rd_addr),
        .o_rdata1 (w_src1_data),
        .o_rdata2 (w_src2_data),
        .o_rdata3 (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_WB;
            ST_WB:   w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_wb    = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_WB:   w_wb    = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = cmd_if.cmd_valid && w_ready;
    // Overflow is judged on the registered operands that the ALU is seeing now
    assign w_ovf    = calc_ovf(r_sel, r_din1, r_din2, alu_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din1     <= '0;
            r_din2     <= '0;
            r_sel      <= '0;
            r_dst      <= '0;
            r_res_data <= '0;
            r_res_dst  <= '0;
            r_res_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel <= cmd_if.cmd_op;
                r_dst <= cmd_if.cmd_dst;
                case (cmd_if.cmd_op)
                    OP_LDI: begin
                        r_din1 <= cmd_if.cmd_imm;
                        r_din2 <= '0;
                    end
                    OP_MOV: begin
                        r_din1 <= w_src1_data;
                        r_din2 <= '0;
                    end
                    default: begin
                        r_din1 <= w_src1_data;
                        r_din2 <= w_src2_data;
                    end
                endcase
            end
            if (r_state == ST_EXEC) begin
                r_res_data <= alu_out;
                r_res_dst  <= r_dst;
                r_res_ovf  <= w_ovf;
            end
        end
    end

    assign alu_din1         = r_din1;
    assign alu_din2         = r_din2;
    assign alu_sel          = r_sel;
    assign cmd_if.cmd_ready = w_ready;
    assign cmd_if.res_valid = w_wb;
    assign cmd_if.res_data  = r_res_data;
    assign cmd_if.res_dst   = r_res_dst;
    assign cmd_if.res_ovf   = r_res_ovf;

endmodule
`default_nettype wire
